// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with architectural HI/LO.
//
// MULT/MULTU use shift-add and DIV/DIVU use restoring shift-subtract. Each takes
// 32 iterations on operand magnitudes, and a sign fixup is applied on the final edge.
//
// Optional feature: define MD_DIV_ZERO_DETECT_EN to add the md_div_zero output.
// With it, a divide by zero skips the iteration loop and leaves HI/LO untouched.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  input  logic [31:0] md_op_x,
  input  logic [31:0] md_op_y,
  input  logic        md_flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] md_wdata,
  output logic        md_busy,
  output logic        md_done,
`ifdef MD_DIV_ZERO_DETECT_EN
  output logic        md_div_zero,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q;     // mult: multiplicand magnitude; div: divisor magnitude
  logic        is_div_q;
  logic        sgn_x_q;
  logic        sgn_y_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
`ifdef MD_DIV_ZERO_DETECT_EN
  logic        dz_q;
`endif

  logic        op_signed_s;
  logic        op_div_s;
  logic        x_neg_s;
  logic        y_neg_s;
  logic [31:0] x_mag_s;
  logic [31:0] y_mag_s;
  logic        start_ok_s;
  logic [32:0] mul_sum_s;
  logic [32:0] rem_sh_s;
  logic [33:0] div_diff_s;
  logic [63:0] acc_step_s;
  logic [63:0] prod_neg_s;
  logic [31:0] quo_neg_s;
  logic [31:0] rem_neg_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  // Decode the launch request: op flavour, operand signs and magnitudes.
  always_comb begin
    op_signed_s = ~md_op[0];
    op_div_s    = md_op[1];
    x_neg_s     = op_signed_s & md_op_x[31];
    y_neg_s     = op_signed_s & md_op_y[31];
    if (x_neg_s) begin
      x_mag_s = 32'd0 - md_op_x;
    end else begin
      x_mag_s = md_op_x;
    end
    if (y_neg_s) begin
      y_mag_s = 32'd0 - md_op_y;
    end else begin
      y_mag_s = md_op_y;
    end
    // Flush wins over a same-cycle start.
    start_ok_s = (state_q == ST_IDLE) & md_start & ~md_flush;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[63:32]};
    rem_sh_s   = {acc_q[63:32], acc_q[31]};
    div_diff_s = {1'b0, rem_sh_s} - {2'b00, opnd_q};
    acc_step_s = acc_q;
    if (is_div_q) begin
      // A negative trial difference means the divisor did not fit: keep the shifted remainder.
      if (div_diff_s[33]) begin
        acc_step_s = {rem_sh_s[31:0], acc_q[30:0], 1'b0};
      end else begin
        acc_step_s = {div_diff_s[31:0], acc_q[30:0], 1'b1};
      end
    end else begin
      if (acc_q[0]) begin
        mul_sum_s = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
      end else begin
        mul_sum_s = {1'b0, acc_q[63:32]};
      end
      acc_step_s = {mul_sum_s, acc_q[31:1]};
    end
  end

  // Sign fixup of the final iteration's result before it is written to HI/LO.
  always_comb begin
    prod_neg_s = 64'd0 - acc_step_s;
    quo_neg_s  = 32'd0 - acc_step_s[31:0];
    rem_neg_s  = 32'd0 - acc_step_s[63:32];
    if (is_div_q) begin
      if (sgn_x_q ^ sgn_y_q) begin
        res_lo_s = quo_neg_s;
      end else begin
        res_lo_s = acc_step_s[31:0];
      end
      // The remainder takes the sign of the dividend.
      if (sgn_x_q) begin
        res_hi_s = rem_neg_s;
      end else begin
        res_hi_s = acc_step_s[63:32];
      end
    end else begin
      if (sgn_x_q ^ sgn_y_q) begin
        res_hi_s = prod_neg_s[63:32];
        res_lo_s = prod_neg_s[31:0];
      end else begin
        res_hi_s = acc_step_s[63:32];
        res_lo_s = acc_step_s[31:0];
      end
    end
  end

  // Control FSM, iteration datapath and HI/LO registers with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      sgn_x_q  <= 1'b0;
      sgn_y_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MD_DIV_ZERO_DETECT_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // MTHI/MTLO land even when a start is accepted; completion overwrites later.
          if (hi_we) begin
            hi_q <= md_wdata;
          end
          if (lo_we) begin
            lo_q <= md_wdata;
          end
          if (start_ok_s) begin
            cnt_q    <= 5'd0;
            is_div_q <= op_div_s;
            sgn_x_q  <= x_neg_s;
            sgn_y_q  <= y_neg_s;
            if (op_div_s) begin
              acc_q  <= {32'd0, x_mag_s};
              opnd_q <= y_mag_s;
            end else begin
              acc_q  <= {32'd0, y_mag_s};
              opnd_q <= x_mag_s;
            end
`ifdef MD_DIV_ZERO_DETECT_EN
            dz_q <= 1'b0;
            if (op_div_s && (md_op_y == 32'd0)) begin
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
`else
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          // HI/LO writes are ignored for the whole RUN state, including the completion edge.
          if (md_flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 5'd0;
          end else begin
            acc_q <= acc_step_s;
            if (cnt_q == 5'd31) begin
              hi_q    <= res_hi_s;
              lo_q    <= res_lo_s;
              cnt_q   <= 5'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        ST_DONE: begin
          // A start here is ignored; decode must wait for IDLE.
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (hi_we) begin
            hi_q <= md_wdata;
          end
          if (lo_we) begin
            lo_q <= md_wdata;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
`ifdef MD_DIV_ZERO_DETECT_EN
  assign md_div_zero = dz_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit.
// Stimulus pushes the expected HI/LO values and completion cycle into a queue.
// A negedge monitor pops the queue and compares whenever md_done is seen.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_op_x;
  logic [31:0] md_op_y;
  logic        md_flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] md_wdata;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MD_DIV_ZERO_DETECT_EN
  logic        md_div_zero;
`endif

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc        = 0;
  int   n_chk      = 0;
  int   n_fail     = 0;
  int   done_count = 0;

  mult_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_op_x    (md_op_x),
    .md_op_y    (md_op_y),
    .md_flush   (md_flush),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .md_wdata   (md_wdata),
    .md_busy    (md_busy),
    .md_done    (md_done),
`ifdef MD_DIV_ZERO_DETECT_EN
    .md_div_zero(md_div_zero),
`endif
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Scoreboard monitor: every md_done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && md_done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_hi"}, {32'd0, hi}, {32'd0, mon_e.hi});
        chk({mon_e.name, "_lo"}, {32'd0, lo}, {32'd0, mon_e.lo});
        chk({mon_e.name, "_done_cycle"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] eh, input logic [31:0] el,
                          input int lat);
    exp_t e;
    e.name = nm;
    e.hi   = eh;
    e.lo   = el;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic drive_start(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    md_start = 1'b1;
    md_op    = op;
    md_op_x  = x;
    md_op_y  = y;
  endtask

  task automatic scramble_ops();
    md_start = 1'b0;
    md_op    = 2'b10;
    md_op_x  = 32'hA5A5_A5A5;
    md_op_y  = 32'h5A5A_5A5A;
  endtask

  // Wait (bounded) for the scoreboard to drain, then one more cycle so the FSM is IDLE.
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({nm, "_done_timeout"}, 64'd1, 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    @(negedge clk);
    drive_start(op, x, y);
    push_exp(nm, eh, el, lat);
    @(negedge clk);
    scramble_ops();
    wait_done(nm);
  endtask

  initial begin
    int busy_err;
    int d0;
    rst      = 1'b1;
    md_start = 1'b0;
    md_op    = 2'b00;
    md_op_x  = 32'd0;
    md_op_y  = 32'd0;
    md_flush = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    md_wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, md_busy}, 64'd0);
    chk("reset_done", {63'd0, md_done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // MULTU all-ones with busy window check
    @(negedge clk);
    drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp("multu_ones", 32'hFFFF_FFFE, 32'h0000_0001, 33);
    busy_err = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) scramble_ops();
      if (md_busy !== 1'b1) busy_err++;
    end
    chk("busy_cycles_1_32_errors", 64'(busy_err), 64'd0);
    @(negedge clk);
    #1;
    chk("busy_cycle33", {63'd0, md_busy}, 64'd0);
    wait_done("multu_ones");

    // MULT -3*5, with a start attempt during DONE that must be ignored
    @(negedge clk);
    drive_start(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    push_exp("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) scramble_ops();
    end
    drive_start(OP_MULTU, 32'd2, 32'd3);
    @(negedge clk);
    scramble_ops();
    #1;
    chk("start_in_done_busy", {63'd0, md_busy}, 64'd0);
    @(negedge clk);
    #1;
    chk("start_in_done_busy2", {63'd0, md_busy}, 64'd0);
    chk("start_in_done_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFF1});

    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
`ifdef MD_DIV_ZERO_DETECT_EN
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0000, 32'h8000_0000, 1);
    chk("div_zero_flag", {63'd0, md_div_zero}, 64'd1);
`else
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 33);
`endif
    run_op("mult_minint_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("multu_2p16", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 33);

    // MTLO in IDLE
    @(negedge clk);
    lo_we    = 1'b1;
    md_wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    chk("mtlo_idle", {32'd0, lo}, {32'd0, 32'h0000_1234});

    // MTHI with accepted start, MTLO while busy, MTLO at the completion edge
    @(negedge clk);
    drive_start(OP_MULTU, 32'd2, 32'd3);
    hi_we    = 1'b1;
    md_wdata = 32'h0000_DEAD;
    push_exp("multu_2_3", 32'd0, 32'd6, 33);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) begin
        scramble_ops();
        hi_we = 1'b0;
        chk("mthi_with_start", {32'd0, hi}, {32'd0, 32'h0000_DEAD});
      end
      if (k == 5) begin
        lo_we    = 1'b1;
        md_wdata = 32'h0000_5678;
      end
      if (k == 6) begin
        lo_we = 1'b0;
        chk("mtlo_busy_ignored", {32'd0, lo}, {32'd0, 32'h0000_1234});
      end
      if (k == 32) begin
        lo_we    = 1'b1;
        md_wdata = 32'h0000_9999;
      end
      if (k == 33) lo_we = 1'b0;
    end
    wait_done("multu_2_3");

    // Flush at cycle 10: no result, no md_done
    @(negedge clk);
    hi_we    = 1'b1;
    md_wdata = 32'h0000_0011;
    @(negedge clk);
    hi_we    = 1'b0;
    lo_we    = 1'b1;
    md_wdata = 32'h0000_0022;
    @(negedge clk);
    lo_we = 1'b0;
    d0 = done_count;
    drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) scramble_ops();
    end
    chk("flush_busy_before", {63'd0, md_busy}, 64'd1);
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    #1;
    chk("flush_busy_after", {63'd0, md_busy}, 64'd0);
    chk("flush_hi", {32'd0, hi}, {32'd0, 32'h0000_0011});
    chk("flush_lo", {32'd0, lo}, {32'd0, 32'h0000_0022});
    repeat (40) @(negedge clk);
    chk("flush_no_done", 64'(done_count), 64'(d0));

    // Reset at cycle 10: registers cleared, no md_done
    @(negedge clk);
    d0 = done_count;
    drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) scramble_ops();
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_busy", {63'd0, md_busy}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 64'(done_count), 64'(d0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
